// File: rtl/anthem_stream_checker.sv
// anthem_stream_checker: receive-side checker for the anthem/credits
// byte stream; hunts, tracks, locks and counts mismatches.
module anthem_stream_checker #(
  parameter int LEN_A = 64,
  parameter int LEN_B = 77,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       din,
  input  logic             din_valid,
  input  logic [1:0]       msg_sel,
  output logic             locked,
  output logic             msg_done,
  output logic [6:0]       exp_idx,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    TRACK  = 2'b01,
    LOCKED = 2'b10
  } state_t;

  localparam logic [8*64-1:0] ROM_A = {
    8'hA1, "Soy de Zacapa! tierra caliente,",
    8'h0A, "nac", 8'hED, " en el barrio El Tamarindal"
  };

  localparam logic [8*77-1:0] ROM_B =
    "PProyecto trabajado por Angel Orellana, Daniel Mundo, Julio Lopez y Noel Prad";

  localparam logic [6:0] LAST_A = 7'(LEN_A - 1);
  localparam logic [6:0] LAST_B = 7'(LEN_B - 1);

  function automatic logic [7:0] rom_byte(
    input logic       sel_b,
    input logic [6:0] idx
  );
    logic [7:0] v;
    v = 8'h00;
    if (sel_b) begin
      if (idx < 7'd77) v = ROM_B[8*(76-int'(idx)) +: 8];
    end else begin
      if (idx < 7'd64) v = ROM_A[8*(63-int'(idx)) +: 8];
    end
    return v;
  endfunction

  state_t           r_state, w_state;
  logic [6:0]       r_idx, w_idx;
  logic             r_locked, w_locked;
  logic             r_done, w_done;
  logic [ERR_W-1:0] r_err, w_err;
  logic             r_sel_b;

  logic             w_sel_b;
  logic [6:0]       w_last;
  logic [7:0]       w_exp;
  logic [7:0]       w_first;
  logic [ERR_W-1:0] w_err_inc;

  // 00/11 both mean A, 01/10 both mean B
  assign w_sel_b   = msg_sel[0] ^ msg_sel[1];
  assign w_last    = w_sel_b ? LAST_B : LAST_A;
  assign w_exp     = rom_byte(w_sel_b, r_idx);
  assign w_first   = rom_byte(w_sel_b, 7'd0);
  assign w_err_inc = (r_err == '1) ? r_err : r_err + 1'b1;

  // next-state: selection change first, then valid-byte processing
  always_comb begin
    w_state  = r_state;
    w_idx    = r_idx;
    w_locked = r_locked;
    w_done   = 1'b0;
    w_err    = r_err;
    if (w_sel_b != r_sel_b) begin
      w_state  = HUNT;
      w_idx    = 7'd0;
      w_locked = 1'b0;
    end else if (din_valid) begin
      unique case (r_state)
        HUNT: begin
          if (din == w_first) begin
            w_state = TRACK;
            w_idx   = 7'd1;
          end
        end
        TRACK, LOCKED: begin
          if (din == w_exp) begin
            if (r_idx == w_last) begin
              w_idx    = 7'd0;
              w_done   = 1'b1;
              w_locked = 1'b1;
              w_state  = LOCKED;
            end else begin
              w_idx = r_idx + 7'd1;
            end
          end else begin
            w_err    = w_err_inc;
            w_locked = 1'b0;
            if (din == w_first) begin
              w_state = TRACK;
              w_idx   = 7'd1;
            end else begin
              w_state = HUNT;
              w_idx   = 7'd0;
            end
          end
        end
        default: begin
          w_state = HUNT;
          w_idx   = 7'd0;
        end
      endcase
    end
  end

  // state and output registers; reset is active-high here
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state  <= HUNT;
      r_idx    <= 7'd0;
      r_locked <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= '0;
      r_sel_b  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_idx    <= w_idx;
      r_locked <= w_locked;
      r_done   <= w_done;
      r_err    <= w_err;
      r_sel_b  <= w_sel_b;
    end
  end

  assign locked   = r_locked;
  assign msg_done = r_done;
  assign exp_idx  = r_idx;
  assign err_cnt  = r_err;
  assign state    = r_state;

endmodule

// File: tb/tb_anthem_stream_checker.sv
// tb_anthem_stream_checker: randomized stimulus against a
// message-level reference model of the stream checker.
module tb_anthem_stream_checker;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic [1:0] msg_sel;
  logic       locked;
  logic       msg_done;
  logic [6:0] exp_idx;
  logic [7:0] err_cnt;
  logic [1:0] state;

  anthem_stream_checker #(
    .LEN_A(64), .LEN_B(77), .ERR_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .msg_sel(msg_sel), .locked(locked), .msg_done(msg_done),
    .exp_idx(exp_idx), .err_cnt(err_cnt), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [8*64-1:0] TA = {
    8'hA1, "Soy de Zacapa! tierra caliente,",
    8'h0A, "nac", 8'hED, " en el barrio El Tamarindal"
  };
  localparam logic [8*77-1:0] TB_ =
    "PProyecto trabajado por Angel Orellana, Daniel Mundo, Julio Lopez y Noel Prad";

  logic [7:0] romA [64];
  logic [7:0] romB [77];

  int checks = 0;
  int failures = 0;

  // reference model: 0 hunting, 1 tracking, 2 locked
  int m_state, m_idx, m_err;
  bit m_locked, m_done, m_selb;

  logic [18:0] got;
  assign got = {state, exp_idx, locked, msg_done, err_cnt};

  function automatic logic [18:0] mvec();
    return {2'(m_state), 7'(m_idx), m_locked, m_done, 8'(m_err)};
  endfunction

  function automatic logic [7:0] mrom(input bit b, input int i);
    return b ? romB[i] : romA[i];
  endfunction

  task automatic m_reset();
    m_state = 0; m_idx = 0; m_err = 0;
    m_locked = 0; m_done = 0; m_selb = 0;
  endtask

  task automatic model_edge(input logic [7:0] d, input logic v,
                            input logic [1:0] s);
    bit sb;
    int len;
    sb = s[0] ^ s[1];
    len = sb ? 77 : 64;
    m_done = 0;
    if (sb != m_selb) begin
      m_state = 0; m_idx = 0; m_locked = 0;
    end else if (v) begin
      if (m_state == 0) begin
        if (d == mrom(sb, 0)) begin m_state = 1; m_idx = 1; end
      end else if (d == mrom(sb, m_idx)) begin
        m_idx = (m_idx + 1) % len;
        if (m_idx == 0) begin
          m_done = 1; m_locked = 1; m_state = 2;
        end
      end else begin
        if (m_err < 255) m_err++;
        m_locked = 0;
        if (d == mrom(sb, 0)) begin m_state = 1; m_idx = 1; end
        else begin m_state = 0; m_idx = 0; end
      end
    end
    m_selb = sb;
  endtask

  task automatic send(input logic [7:0] d, input logic v);
    din = d;
    din_valid = v;
    model_edge(d, v, msg_sel);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    msg_sel = 2'b00;
    din = 8'h00;
    din_valid = 1'b0;
    m_reset();
    #1;
    checks++;
    if (got !== 19'd0) begin
      failures++;
      $display("FAIL reset_t1 got=%h exp=%h", got, 19'd0);
    end
    for (int i = 0; i < 4; i++) begin
      din_valid = ~din_valid;
      din = 8'($urandom);
      #7;
      checks++;
      if (got !== 19'd0) begin
        failures++;
        $display("FAIL reset_hold%0d got=%h exp=%h", i, got, 19'd0);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic test_a_twice();
    msg_sel = 2'b00;
    for (int i = 0; i < 128; i++) begin
      send(romA[i % 64], 1'b1);
      checks++;
      if (got !== mvec()) begin
        failures++;
        $display("FAIL a2_model i=%0d got=%h exp=%h", i, got, mvec());
      end
      checks++;
      if ({msg_done, locked, exp_idx, err_cnt} !==
          {(i % 64) == 63, i >= 63, 7'((i + 1) % 64), 8'd0}) begin
        failures++;
        $display("FAIL a2_spec i=%0d done=%b lock=%b idx=%0d err=%0d",
                 i, msg_done, locked, exp_idx, err_cnt);
      end
    end
  endtask

  task automatic test_corrupt();
    logic [7:0] d;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 64; i++) begin
        d = (p == 0 && i == 20) ? 8'h00 : romA[i];
        send(d, 1'b1);
        checks++;
        if (got !== mvec()) begin
          failures++;
          $display("FAIL corrupt_model p=%0d i=%0d got=%h exp=%h",
                   p, i, got, mvec());
        end
        if (p == 0 && i == 20) begin
          checks++;
          if ({err_cnt, locked, state} !== {8'd1, 1'b0, 2'b00}) begin
            failures++;
            $display("FAIL corrupt_hit err=%0d lock=%b st=%b exp 1/0/00",
                     err_cnt, locked, state);
          end
        end
        if (p == 1 && i == 63) begin
          checks++;
          if ({msg_done, locked, state} !== 4'b1110) begin
            failures++;
            $display("FAIL corrupt_relock done=%b lock=%b st=%b exp 1/1/10",
                     msg_done, locked, state);
          end
        end
      end
    end
  endtask

  task automatic test_b_gaps();
    logic [7:0] q[$];
    int saved;
    pulse_reset();
    msg_sel = 2'b01;
    send(8'h00, 1'b0);
    for (int i = 1; i < 77; i++) q.push_back(romB[i]);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 77; i++) q.push_back(romB[i]);
    saved = 0;
    for (int k = 0; k < q.size(); k++) begin
      while ($urandom_range(0, 2) == 0) begin
        send(8'($urandom), 1'b0);
        checks++;
        if (got !== mvec()) begin
          failures++;
          $display("FAIL b_gap k=%0d got=%h exp=%h", k, got, mvec());
        end
      end
      if (k == 76 + 77 + 30) msg_sel = 2'b10;
      if (k == 76 + 77 + 50) begin
        saved = int'(err_cnt);
        msg_sel = 2'b00;
      end
      send(q[k], 1'b1);
      checks++;
      if (got !== mvec()) begin
        failures++;
        $display("FAIL b_model k=%0d got=%h exp=%h", k, got, mvec());
      end
      if (k == 1) begin
        checks++;
        if ({err_cnt, state} !== {8'd1, 2'b00}) begin
          failures++;
          $display("FAIL b_entry err=%0d st=%b exp 1/00", err_cnt, state);
        end
      end
      if (k == 76 + 76) begin
        checks++;
        if ({msg_done, locked} !== 2'b11) begin
          failures++;
          $display("FAIL b_lock done=%b lock=%b exp 11", msg_done, locked);
        end
      end
      if (k == 76 + 77 + 30) begin
        checks++;
        if ({state, locked} !== 3'b101) begin
          failures++;
          $display("FAIL sel_alias st=%b lock=%b exp 10/1", state, locked);
        end
      end
      if (k == 76 + 77 + 50) begin
        checks++;
        if ({state, locked, err_cnt} !== {2'b00, 1'b0, 8'(saved)}) begin
          failures++;
          $display("FAIL sel_change st=%b lock=%b err=%0d exp 00/0/%0d",
                   state, locked, err_cnt, saved);
        end
      end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] bad;
    int prev;
    msg_sel = 2'b00;
    send(8'h00, 1'b0);
    prev = int'(err_cnt);
    for (int n = 0; n < 300; n++) begin
      send(8'hA1, 1'b1);
      bad = 8'($urandom);
      if (bad == 8'h53 || bad == 8'hA1) bad = 8'h00;
      send(bad, 1'b1);
      checks++;
      if (got !== mvec() || int'(err_cnt) < prev) begin
        failures++;
        $display("FAIL sat_step n=%0d got=%h exp=%h", n, got, mvec());
      end
      prev = int'(err_cnt);
    end
    checks++;
    if (err_cnt !== 8'd255) begin
      failures++;
      $display("FAIL sat_final err=%0d exp 255", err_cnt);
    end
  endtask

  task automatic test_mid_reset();
    msg_sel = 2'b00;
    for (int i = 0; i < 40; i++) send(romA[i], 1'b1);
    checks++;
    if (got !== mvec()) begin
      failures++;
      $display("FAIL mid_pre got=%h exp=%h", got, mvec());
    end
    #2;
    rst_n = 1'b1;
    m_reset();
    #1;
    checks++;
    if (got !== 19'd0) begin
      failures++;
      $display("FAIL mid_async got=%h exp=%h", got, 19'd0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) begin
      send(romA[i], 1'b1);
      checks++;
      if (got !== mvec()) begin
        failures++;
        $display("FAIL mid_resume i=%0d got=%h exp=%h", i, got, mvec());
      end
    end
    checks++;
    if ({msg_done, locked, err_cnt} !== {2'b11, 8'd0}) begin
      failures++;
      $display("FAIL mid_lock done=%b lock=%b err=%0d exp 1/1/0",
               msg_done, locked, err_cnt);
    end
  endtask

  task automatic test_random();
    int p;
    logic [7:0] d;
    logic v;
    pulse_reset();
    p = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 60) == 0) msg_sel = 2'($urandom);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 40) == 0) d = 8'($urandom);
      else d = (msg_sel[0] ^ msg_sel[1]) ? romB[p % 77] : romA[p % 64];
      if (v) p++;
      send(d, v);
      checks++;
      if (got !== mvec()) begin
        failures++;
        $display("FAIL rand n=%0d got=%h exp=%h", n, got, mvec());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) romA[i] = TA[8*(63-i) +: 8];
    for (int i = 0; i < 77; i++) romB[i] = TB_[8*(76-i) +: 8];
    test_reset();
    test_a_twice();
    test_corrupt();
    test_b_gaps();
    test_saturate();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
